uart_host_ctrl: RTL and testbench
=================================

# uart_host_ctrl

- Receives host commands over 8N1 UART and decodes them into one-cycle strobes that load weights and activations and start the MLP.
- Answers status and accumulator reads by serialising bytes back over UART.
- Sits between the board UART pins and the TPU bridge/MLP; the bridge forwards its strobes to the MLP and returns MLP status.

## Interface
- CLOCK_FREQ, 100_000_000, clk frequency in Hz.
- BAUD_RATE, 115200, UART bit rate; BIT_DIV = CLOCK_FREQ/BAUD_RATE clocks per bit (integer division).
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-low; clock clk.
- uart_rx  in  1  serial input, idle high, asynchronous to clk.
- uart_tx  out  1  serial output, idle high.
- wf_push_col0, wf_push_col1  out  1 each  one-cycle weight FIFO push strobes.
- wf_data_in  out  8  weight byte, valid with a push strobe.
- wf_reset  out  1  one-cycle weight FIFO clear strobe.
- init_act_valid  out  1  one-cycle strobe.
- init_act_data  out  16  activation word, valid with init_act_valid.
- start_mlp  out  1  one-cycle strobe.
- weights_ready  out  1  level.
- mlp_state  in  4  MLP FSM state.
- mlp_cycle_cnt  in  5  MLP cycle counter.
- mlp_acc0  in  32 signed  MLP accumulator 0.
- dbg_state  out  4  controller state code.
- dbg_cmd_reg  out  8  latched command byte.
- dbg_byte_count  out  3  payload bytes received.
- dbg_resp_byte_idx  out  2  response byte index.
- dbg_tx_valid, dbg_tx_ready  out  1 each  internal TX handshake.
- dbg_rx_valid  out  1  RX byte strobe.
- dbg_rx_data  out  8  last RX byte.
- dbg_weights_ready, dbg_start_mlp  out  1 each  copies of weights_ready and start_mlp.

## Operation
- RX: 2-flop synchroniser; falling edge starts a frame. Start bit re-checked at BIT_DIV/2; each data bit sampled at its mid-bit, LSB first. Stop bit sampled; if 0 the byte is discarded. Good byte: rx_valid pulses 1 cycle and rx_data updates.
- TX: tx_valid/tx_ready handshake. tx_ready is high when idle; a byte is accepted when both are high. Frame: start, 8 data bits LSB first, stop; each bit lasts BIT_DIV clocks.
- FSM states: IDLE=0, RECV=1, EXEC=2, SEND=3, WAIT_TX=4.
- IDLE, on rx_valid: latch cmd_reg and clear byte_count. Go to RECV if the command has payload, else EXEC.
- RECV: each rx_valid stores a byte and increments byte_count. When byte_count reaches the payload length, go to EXEC.
- EXEC: issue strobes, load the response, then go to SEND if there is a response, else IDLE.
- SEND: assert tx_valid with resp[resp_idx]. On acceptance, go to WAIT_TX.
- WAIT_TX: on tx_ready, increment resp_idx; go back to SEND if more bytes remain, else IDLE.
- Commands:
  - 0x01: 2 payload bytes. Each pushes col0 one cycle after it is received, with wf_data_in = byte.
  - 0x02: same as 0x01, for col1.
  - 0x03: 2 payload bytes, low byte first. init_act_data = {b1,b0}, init_act_valid pulses in EXEC.
  - 0x04: start_mlp pulse.
  - 0x05: weights_ready set to 1.
  - 0x06: wf_reset pulse; weights_ready cleared to 0.
  - 0x07: response {4'h0,mlp_state}, then {3'b0,mlp_cycle_cnt}.
  - 0x08: response of 4 bytes of mlp_acc0, little-endian, snapshotted in EXEC.
  - Any other value: ignored, return to IDLE.
- Bytes that arrive while in EXEC, SEND or WAIT_TX are dropped.

## Timing
- Reset value of every output: uart_tx=1, all others 0. Reset mid-frame aborts RX, TX and FSM immediately.
- Strobes are exactly 1 cycle wide; never two strobes in the same cycle.
- rx_valid latency: BIT_DIV/2 clocks after the stop-bit midpoint, ±2 sync cycles.
- Push strobe: 1 cycle after rx_valid. EXEC lasts 1 cycle.
- First TX start bit: 2 cycles after EXEC. Response bytes are sent back-to-back with no idle gap beyond 1 cycle.
- A response or ack is completely transmitted before the next command is accepted.

## Configuration
- UART_HOST_ACK_EN defined: commands 0x01–0x06 transmit one ack byte 0xAA after EXEC, through SEND.
- UART_HOST_ACK_EN undefined: those commands return directly to IDLE with no TX activity.

## Test plan
All scenarios use CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT_DIV=10).
- Reset: hold rst=0 for 5 cycles -> uart_tx=1, all strobes 0, dbg_state=0.
- Weight loads: send 0x01,0x11,0x22 then 0x02,0x33,0x44. Required:
  - col0 pushes with data 0x11 then 0x22;
  - col1 pushes with data 0x33 then 0x44;
  - each push is 1 cycle wide.
- Activation and start: send 0x03,0x34,0x12 -> init_act_valid with data 0x1234. Then send 0x05,0x04 -> weights_ready=1, then a 1-cycle start_mlp.
- Accumulator read: mlp_acc0=0xDEADBEEF, send 0x08 -> TX bytes EF,BE,AD,DE.
- Status read: mlp_state=3, mlp_cycle_cnt=17, send 0x07 -> TX bytes 0x03,0x11.
- Error cases, each required to return to IDLE with no strobes:
  - byte with stop bit 0 is dropped;
  - unknown command 0x7F is ignored;
  - rst=0 mid-payload aborts the frame.

Source files
------------

// File: rtl/uart_host_ctrl_if.sv
// Strobe/status bus between the UART host controller and the TPU bridge/MLP.
interface uart_host_ctrl_if;
  logic               wf_push_col0;
  logic               wf_push_col1;
  logic [7:0]         wf_data_in;
  logic               wf_reset;
  logic               init_act_valid;
  logic [15:0]        init_act_data;
  logic               start_mlp;
  logic               weights_ready;
  logic [3:0]         mlp_state;
  logic [4:0]         mlp_cycle_cnt;
  logic signed [31:0] mlp_acc0;

  modport master (
    output wf_push_col0, wf_push_col1, wf_data_in, wf_reset,
    output init_act_valid, init_act_data, start_mlp, weights_ready,
    input  mlp_state, mlp_cycle_cnt, mlp_acc0
  );

  modport slave (
    input  wf_push_col0, wf_push_col1, wf_data_in, wf_reset,
    input  init_act_valid, init_act_data, start_mlp, weights_ready,
    output mlp_state, mlp_cycle_cnt, mlp_acc0
  );
endinterface

// File: rtl/uart_host_ctrl.sv
// UART 8N1 host command decoder driving MLP load/start strobes and status readback.
// Optional: define UART_HOST_ACK_EN to answer commands 0x01-0x06 with an 0xAA ack byte.
module uart_host_ctrl #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rx,
  output logic                    uart_tx,
  uart_host_ctrl_if.master        mlp_bus,
  output logic [3:0]              dbg_state,
  output logic [7:0]              dbg_cmd_reg,
  output logic [2:0]              dbg_byte_count,
  output logic [1:0]              dbg_resp_byte_idx,
  output logic                    dbg_tx_valid,
  output logic                    dbg_tx_ready,
  output logic                    dbg_rx_valid,
  output logic [7:0]              dbg_rx_data,
  output logic                    dbg_weights_ready,
  output logic                    dbg_start_mlp
);
  localparam int BIT_DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W   = $clog2(BIT_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(BIT_DIV - 2);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE} rx_state_t;
  typedef enum logic [3:0] {S_IDLE = 4'd0, S_RECV = 4'd1, S_EXEC = 4'd2,
                            S_SEND = 4'd3, S_WAIT_TX = 4'd4} state_t;

  rx_state_t        r_rx_state;
  logic [2:0]       r_rx_sync;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_rx_stop;
  logic             r_rx_valid;
  logic [7:0]       r_rx_data;
  logic             w_rx;
  logic             w_rx_fall;

  logic             r_tx_busy;
  logic             r_tx_ready;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_bit;
  logic [9:0]       r_tx_shift;

  state_t           r_state;
  logic [7:0]       r_cmd;
  logic [2:0]       r_byte_count;
  logic [7:0]       r_b0;
  logic [7:0]       r_b1;
  logic [7:0]       r_resp [4];
  logic [1:0]       r_resp_last;
  logic [1:0]       r_resp_idx;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;

  assign w_rx      = r_rx_sync[1];
  assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];

  // RX: synchronise, then sample mid-bit; the strobe fires half a bit after the stop midpoint
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_sync  <= 3'b111;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_stop  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_sync  <= {r_rx_sync[1:0], uart_rx};
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (w_rx_fall) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else r_rx_bit <= r_rx_bit + 3'd1;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        RX_STOP: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_stop  <= w_rx;
            r_rx_state <= RX_DONE;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        RX_DONE: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_stop) begin
              r_rx_valid <= 1'b1;
              r_rx_data  <= r_rx_shift;
            end
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // TX: ready rises in the final stop-bit clock so a queued byte follows with a 1-clock gap
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_busy  <= 1'b0;
      r_tx_ready <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      uart_tx    <= 1'b1;
    end else if (!r_tx_busy) begin
      if (r_tx_ready && r_tx_valid) begin
        r_tx_busy  <= 1'b1;
        r_tx_ready <= 1'b0;
        r_tx_cnt   <= '0;
        r_tx_bit   <= '0;
        r_tx_shift <= {1'b1, r_tx_data, 1'b0};
        uart_tx    <= 1'b0;
      end else r_tx_ready <= 1'b1;
    end else if (r_tx_cnt == ((r_tx_bit == 4'd9) ? STOP_LAST : BIT_LAST)) begin
      r_tx_cnt <= '0;
      if (r_tx_bit == 4'd9) begin
        r_tx_busy  <= 1'b0;
        r_tx_ready <= 1'b1;
      end else begin
        r_tx_bit   <= r_tx_bit + 4'd1;
        uart_tx    <= r_tx_shift[1];
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
      end
    end else r_tx_cnt <= r_tx_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state                <= S_IDLE;
      r_cmd                  <= '0;
      r_byte_count           <= '0;
      r_resp_last            <= '0;
      r_resp_idx             <= '0;
      r_tx_valid             <= 1'b0;
      mlp_bus.wf_push_col0   <= 1'b0;
      mlp_bus.wf_push_col1   <= 1'b0;
      mlp_bus.wf_data_in     <= '0;
      mlp_bus.wf_reset       <= 1'b0;
      mlp_bus.init_act_valid <= 1'b0;
      mlp_bus.init_act_data  <= '0;
      mlp_bus.start_mlp      <= 1'b0;
      mlp_bus.weights_ready  <= 1'b0;
    end else begin
      mlp_bus.wf_push_col0   <= 1'b0;
      mlp_bus.wf_push_col1   <= 1'b0;
      mlp_bus.wf_reset       <= 1'b0;
      mlp_bus.init_act_valid <= 1'b0;
      mlp_bus.start_mlp      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_rx_valid) begin
            r_cmd        <= r_rx_data;
            r_byte_count <= '0;
            r_state      <= (r_rx_data inside {8'h01, 8'h02, 8'h03}) ? S_RECV : S_EXEC;
          end
        end
        S_RECV: begin
          if (r_rx_valid) begin
            if (r_byte_count == 3'd0) r_b0 <= r_rx_data;
            else r_b1 <= r_rx_data;
            mlp_bus.wf_data_in   <= r_rx_data;
            mlp_bus.wf_push_col0 <= (r_cmd == 8'h01);
            mlp_bus.wf_push_col1 <= (r_cmd == 8'h02);
            r_byte_count         <= r_byte_count + 3'd1;
            if (r_byte_count == 3'd1) r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_resp_idx <= '0;
          r_state    <= S_IDLE;
          case (r_cmd)
            8'h03: begin
              mlp_bus.init_act_valid <= 1'b1;
              mlp_bus.init_act_data  <= {r_b1, r_b0};
            end
            8'h04: mlp_bus.start_mlp <= 1'b1;
            8'h05: mlp_bus.weights_ready <= 1'b1;
            8'h06: begin
              mlp_bus.wf_reset      <= 1'b1;
              mlp_bus.weights_ready <= 1'b0;
            end
            default: ;
          endcase
          case (r_cmd)
            8'h07: begin
              r_resp[0]   <= {4'h0, mlp_bus.mlp_state};
              r_resp[1]   <= {3'b000, mlp_bus.mlp_cycle_cnt};
              r_resp_last <= 2'd1;
              r_tx_data   <= {4'h0, mlp_bus.mlp_state};
              r_tx_valid  <= 1'b1;
              r_state     <= S_SEND;
            end
            8'h08: begin
              r_resp[0]   <= mlp_bus.mlp_acc0[7:0];
              r_resp[1]   <= mlp_bus.mlp_acc0[15:8];
              r_resp[2]   <= mlp_bus.mlp_acc0[23:16];
              r_resp[3]   <= mlp_bus.mlp_acc0[31:24];
              r_resp_last <= 2'd3;
              r_tx_data   <= mlp_bus.mlp_acc0[7:0];
              r_tx_valid  <= 1'b1;
              r_state     <= S_SEND;
            end
`ifdef UART_HOST_ACK_EN
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06: begin
              r_resp[0]   <= 8'hAA;
              r_resp_last <= 2'd0;
              r_tx_data   <= 8'hAA;
              r_tx_valid  <= 1'b1;
              r_state     <= S_SEND;
            end
`else
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06: r_state <= S_IDLE;
`endif
            default: r_state <= S_IDLE;
          endcase
        end
        S_SEND: begin
          if (r_tx_valid && r_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_WAIT_TX;
          end
        end
        S_WAIT_TX: begin
          if (r_tx_ready) begin
            if (r_resp_idx == r_resp_last) r_state <= S_IDLE;
            else begin
              r_resp_idx <= r_resp_idx + 2'd1;
              r_tx_data  <= r_resp[r_resp_idx + 2'd1];
              r_tx_valid <= 1'b1;
              r_state    <= S_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state         = r_state;
  assign dbg_cmd_reg       = r_cmd;
  assign dbg_byte_count    = r_byte_count;
  assign dbg_resp_byte_idx = r_resp_idx;
  assign dbg_tx_valid      = r_tx_valid;
  assign dbg_tx_ready      = r_tx_ready;
  assign dbg_rx_valid      = r_rx_valid;
  assign dbg_rx_data       = r_rx_data;
  assign dbg_weights_ready = mlp_bus.weights_ready;
  assign dbg_start_mlp     = mlp_bus.start_mlp;
endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed table-driven bench for uart_host_ctrl at BIT_DIV=10.
module tb_uart_host_ctrl;
  logic clk;
  logic rst;
  logic uart_rx;
  logic uart_tx;
  logic [3:0] dbg_state;
  logic [7:0] dbg_cmd_reg;
  logic [2:0] dbg_byte_count;
  logic [1:0] dbg_resp_byte_idx;
  logic dbg_tx_valid, dbg_tx_ready, dbg_rx_valid;
  logic [7:0] dbg_rx_data;
  logic dbg_weights_ready, dbg_start_mlp;

  uart_host_ctrl_if bus ();

  uart_host_ctrl #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx), .mlp_bus(bus),
    .dbg_state(dbg_state), .dbg_cmd_reg(dbg_cmd_reg), .dbg_byte_count(dbg_byte_count),
    .dbg_resp_byte_idx(dbg_resp_byte_idx), .dbg_tx_valid(dbg_tx_valid),
    .dbg_tx_ready(dbg_tx_ready), .dbg_rx_valid(dbg_rx_valid), .dbg_rx_data(dbg_rx_data),
    .dbg_weights_ready(dbg_weights_ready), .dbg_start_mlp(dbg_start_mlp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    int          nb;
    logic [7:0]  b0, b1;
    logic [3:0]  st;
    logic [4:0]  cc;
    logic [31:0] acc;
    int          e_col0;
    logic [15:0] e_c0d;
    int          e_col1;
    logic [15:0] e_c1d;
    int          e_act;
    logic [15:0] e_actd;
    int          e_start, e_wrst;
    logic        e_wr;
    int          e_ntx;
    logic [31:0] e_tx;
  } vec_t;

  vec_t vq[$];

  // Monitor logs, written only by the monitor and TX decoder processes
  logic [7:0]  col0_log[$], col1_log[$], tx_log[$];
  logic [15:0] act_log[$];
  int lat_log[$];
  int n_start = 0, n_wrst = 0, n_rxv = 0;
  int wide_err = 0, multi_err = 0, push_lat_err = 0, exec_err = 0, frame_err = 0;
  int cyc = 0, exec_cyc = 0;
  bit pend = 0;
  logic [4:0] prev_s = '0;
  logic prev_rxv = 0, prev_tx = 1;
  logic [3:0] prev_state = '0;
  bit tb_rxbusy = 0;

  always @(negedge clk) begin
    logic [4:0] s;
    s = {bus.wf_push_col0, bus.wf_push_col1, bus.wf_reset, bus.init_act_valid, bus.start_mlp};
    cyc++;
    if (rst) begin
      if (bus.wf_push_col0) col0_log.push_back(bus.wf_data_in);
      if (bus.wf_push_col1) col1_log.push_back(bus.wf_data_in);
      if (bus.init_act_valid) act_log.push_back(bus.init_act_data);
      if (bus.start_mlp) n_start++;
      if (bus.wf_reset) n_wrst++;
      if (dbg_rx_valid) n_rxv++;
      if ((s & prev_s) != 5'd0) wide_err++;
      if ($countones(s) > 1) multi_err++;
      if ((bus.wf_push_col0 || bus.wf_push_col1) && !prev_rxv) push_lat_err++;
      if (dbg_state == 4'd2) begin
        if (prev_state == 4'd2) exec_err++;
        pend = 1;
        exec_cyc = cyc;
      end else if (pend && prev_tx && !uart_tx) begin
        lat_log.push_back(cyc - exec_cyc);
        pend = 0;
      end
    end else pend = 0;
    prev_s = s;
    prev_rxv = dbg_rx_valid;
    prev_state = dbg_state;
    prev_tx = uart_tx;
  end

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst && !uart_tx) begin
        tb_rxbusy = 1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (10) @(negedge clk);
        if (!uart_tx) frame_err++;
        tx_log.push_back(b);
        tb_rxbusy = 0;
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (10) @(negedge clk);
    end
    uart_rx = stop;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (dbg_state == 4'd0 && dbg_tx_ready && !tb_rxbusy) begin
        ok = 1;
        break;
      end
    end
    check({name, "_idle_timeout"}, 32'(ok), 32'd1);
    repeat (30) @(negedge clk);
  endtask

  function automatic vec_t mk(input string name, input logic [7:0] cmd, input int nb,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [3:0] st, input logic [4:0] cc, input logic [31:0] acc,
                              input int e_col0, input logic [15:0] e_c0d,
                              input int e_col1, input logic [15:0] e_c1d,
                              input int e_act, input logic [15:0] e_actd,
                              input int e_start, input int e_wrst, input logic e_wr,
                              input int e_ntx, input logic [31:0] e_tx);
    vec_t v;
    v.name = name; v.cmd = cmd; v.nb = nb; v.b0 = b0; v.b1 = b1;
    v.st = st; v.cc = cc; v.acc = acc;
    v.e_col0 = e_col0; v.e_c0d = e_c0d; v.e_col1 = e_col1; v.e_c1d = e_c1d;
    v.e_act = e_act; v.e_actd = e_actd; v.e_start = e_start; v.e_wrst = e_wrst;
    v.e_wr = e_wr; v.e_ntx = e_ntx; v.e_tx = e_tx;
`ifdef UART_HOST_ACK_EN
    if (cmd >= 8'h01 && cmd <= 8'h06) begin
      v.e_ntx = 1;
      v.e_tx = 32'h0000_00AA;
    end
`endif
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int n0, n1, na, ns, nw, nt, nl;
    n0 = col0_log.size(); n1 = col1_log.size(); na = act_log.size();
    ns = n_start; nw = n_wrst; nt = tx_log.size(); nl = lat_log.size();
    bus.mlp_state = v.st;
    bus.mlp_cycle_cnt = v.cc;
    bus.mlp_acc0 = $signed(v.acc);
    send_byte(v.cmd, 1'b1);
    if (v.nb > 0) send_byte(v.b0, 1'b1);
    if (v.nb > 1) send_byte(v.b1, 1'b1);
    wait_idle(v.name);
    check({v.name, "_col0_cnt"}, 32'(col0_log.size() - n0), 32'(v.e_col0));
    for (int k = 0; k < v.e_col0; k++)
      check({v.name, "_col0_data"}, (col0_log.size() > n0 + k) ? 32'(col0_log[n0 + k]) : 32'hFFFF_FFFF,
            32'(v.e_c0d[8*k +: 8]));
    check({v.name, "_col1_cnt"}, 32'(col1_log.size() - n1), 32'(v.e_col1));
    for (int k = 0; k < v.e_col1; k++)
      check({v.name, "_col1_data"}, (col1_log.size() > n1 + k) ? 32'(col1_log[n1 + k]) : 32'hFFFF_FFFF,
            32'(v.e_c1d[8*k +: 8]));
    check({v.name, "_act_cnt"}, 32'(act_log.size() - na), 32'(v.e_act));
    if (v.e_act > 0)
      check({v.name, "_act_data"}, (act_log.size() > na) ? 32'(act_log[na]) : 32'hFFFF_FFFF, 32'(v.e_actd));
    check({v.name, "_start_cnt"}, 32'(n_start - ns), 32'(v.e_start));
    check({v.name, "_wf_reset_cnt"}, 32'(n_wrst - nw), 32'(v.e_wrst));
    check({v.name, "_weights_ready"}, 32'(bus.weights_ready), 32'(v.e_wr));
    check({v.name, "_tx_cnt"}, 32'(tx_log.size() - nt), 32'(v.e_ntx));
    for (int k = 0; k < v.e_ntx; k++)
      check({v.name, "_tx_byte"}, (tx_log.size() > nt + k) ? 32'(tx_log[nt + k]) : 32'hFFFF_FFFF,
            32'(v.e_tx[8*k +: 8]));
    if (v.e_ntx > 0)
      check({v.name, "_tx_start_lat"}, (lat_log.size() > nl) ? 32'(lat_log[lat_log.size() - 1]) : 32'hFFFF_FFFF,
            32'd2);
    check({v.name, "_state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int n0, n1, ns, nr;
    rst = 1'b0;
    uart_rx = 1'b1;
    bus.mlp_state = '0;
    bus.mlp_cycle_cnt = '0;
    bus.mlp_acc0 = '0;

    vq.push_back(mk("wcol0",  8'h01, 2, 8'h11, 8'h22, 4'h0, 5'd0,  32'h0, 2, 16'h2211, 0, 16'h0, 0, 16'h0, 0, 0, 1'b0, 0, 32'h0));
    vq.push_back(mk("wcol1",  8'h02, 2, 8'h33, 8'h44, 4'h0, 5'd0,  32'h0, 0, 16'h0, 2, 16'h4433, 0, 16'h0, 0, 0, 1'b0, 0, 32'h0));
    vq.push_back(mk("act",    8'h03, 2, 8'h34, 8'h12, 4'h0, 5'd0,  32'h0, 0, 16'h0, 0, 16'h0, 1, 16'h1234, 0, 0, 1'b0, 0, 32'h0));
    vq.push_back(mk("wrdy",   8'h05, 0, 8'h00, 8'h00, 4'h0, 5'd0,  32'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 1'b1, 0, 32'h0));
    vq.push_back(mk("start",  8'h04, 0, 8'h00, 8'h00, 4'h0, 5'd0,  32'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 1, 0, 1'b1, 0, 32'h0));
    vq.push_back(mk("acc",    8'h08, 0, 8'h00, 8'h00, 4'h0, 5'd0,  32'hDEADBEEF, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 1'b1, 4, 32'hDEADBEEF));
    vq.push_back(mk("stat",   8'h07, 0, 8'h00, 8'h00, 4'h3, 5'd17, 32'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 1'b1, 2, 32'h0000_1103));
    vq.push_back(mk("unk7f",  8'h7F, 0, 8'h00, 8'h00, 4'h0, 5'd0,  32'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 1'b1, 0, 32'h0));
    vq.push_back(mk("wfrst",  8'h06, 0, 8'h00, 8'h00, 4'h0, 5'd0,  32'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 1, 1'b0, 0, 32'h0));
    vq.push_back(mk("acc2",   8'h08, 0, 8'h00, 8'h00, 4'h0, 5'd0,  32'h8000_0001, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 1'b0, 4, 32'h8000_0001));
    vq.push_back(mk("stat2",  8'h07, 0, 8'h00, 8'h00, 4'hF, 5'd31, 32'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 1'b0, 2, 32'h0000_1F0F));

    repeat (5) @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_push", 32'({bus.wf_push_col0, bus.wf_push_col1}), 32'd0);
    check("rst_wf_reset", 32'(bus.wf_reset), 32'd0);
    check("rst_act_valid", 32'(bus.init_act_valid), 32'd0);
    check("rst_start", 32'(bus.start_mlp), 32'd0);
    check("rst_weights_ready", 32'(bus.weights_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_tx_hs", 32'({dbg_tx_valid, dbg_tx_ready}), 32'd0);
    check("rst_rx_valid", 32'(dbg_rx_valid), 32'd0);
    check("rst_cmd_reg", 32'(dbg_cmd_reg), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    foreach (vq[i]) run_vec(vq[i]);

    // Bad stop bit: byte must be dropped, then a good byte still decodes
    nr = n_rxv; ns = n_start;
    send_byte(8'h04, 1'b0);
    repeat (40) @(negedge clk);
    check("badstop_rx_valid", 32'(n_rxv - nr), 32'd0);
    check("badstop_start", 32'(n_start - ns), 32'd0);
    check("badstop_state", 32'(dbg_state), 32'd0);
    send_byte(8'h04, 1'b1);
    wait_idle("goodstop");
    check("goodstop_start", 32'(n_start - ns), 32'd1);

    // Reset in the middle of the second payload byte
    n0 = col0_log.size();
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    check("midrst_push_cnt", 32'(col0_log.size() - n0), 32'd1);
    check("midrst_push_data", (col0_log.size() > n0) ? 32'(col0_log[n0]) : 32'hFFFF_FFFF, 32'h55);
    check("midrst_state_recv", 32'(dbg_state), 32'd1);
    check("midrst_byte_count", 32'(dbg_byte_count), 32'd1);
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    check("midrst_state_abort", 32'(dbg_state), 32'd0);
    check("midrst_count_abort", 32'(dbg_byte_count), 32'd0);
    check("midrst_uart_tx", 32'(uart_tx), 32'd1);
    rst = 1'b1;
    n0 = col0_log.size(); nr = n_rxv;
    repeat (200) @(negedge clk);
    check("midrst_no_push", 32'(col0_log.size() - n0), 32'd0);
    check("midrst_no_rx", 32'(n_rxv - nr), 32'd0);
    check("midrst_idle", 32'(dbg_state), 32'd0);
    n1 = col1_log.size();
    send_byte(8'h02, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    wait_idle("postrst");
    check("postrst_col1_cnt", 32'(col1_log.size() - n1), 32'd2);
    check("postrst_col1_d0", (col1_log.size() > n1) ? 32'(col1_log[n1]) : 32'hFFFF_FFFF, 32'h66);
    check("postrst_col1_d1", (col1_log.size() > n1 + 1) ? 32'(col1_log[n1 + 1]) : 32'hFFFF_FFFF, 32'h77);

    check("strobe_width_errors", 32'(wide_err), 32'd0);
    check("strobe_overlap_errors", 32'(multi_err), 32'd0);
    check("push_latency_errors", 32'(push_lat_err), 32'd0);
    check("exec_length_errors", 32'(exec_err), 32'd0);
    check("tx_framing_errors", 32'(frame_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
